// File: rtl/tile_pkg.sv
// Shared types and defaults for the tile scan block.
// Lane i of any packed edge bus lives at [W*i +: W].
package tile_pkg;

    localparam int unsigned W_DEFAULT       = 18;
    localparam int unsigned N_EDGES_DEFAULT = 3;

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

    function automatic int unsigned lane_lo(input int unsigned w, input int unsigned i);
        return w * i;
    endfunction

endpackage

// File: rtl/tile_edge_step.sv
// N parallel W-bit edge-function adders (add or subtract) plus an inside test
// on the incoming values: inside when no lane has its sign bit set.
module tile_edge_step
    import tile_pkg::*;
#(
    parameter int unsigned W = W_DEFAULT,
    parameter int unsigned N = N_EDGES_DEFAULT
) (
    input  logic [W*N-1:0] e_i,
    input  logic [W*N-1:0] d_i,
    input  logic           sub_i,
    output logic [W*N-1:0] sum_o,
    output logic           inside_o
);

    logic [N-1:0] sign;

    for (genvar i = 0; i < N; i++) begin : g_lane
        localparam int unsigned Lo = lane_lo(W, i);
        assign sum_o[Lo +: W] = sub_i ? (e_i[Lo +: W] - d_i[Lo +: W])
                                      : (e_i[Lo +: W] + d_i[Lo +: W]);
        assign sign[i] = e_i[Lo + W - 1];
    end

    assign inside_o = ~|sign;

endmodule

// File: rtl/tile_scan.sv
// Walks a TW x TH tile over N_EDGES edge functions, streaming one coverage sample per pixel.
// Define TILE_SCAN_SERPENTINE_EN for boustrophedon order (odd rows run right to left).
module tile_scan
    import tile_pkg::*;
#(
    parameter int unsigned W       = W_DEFAULT,
    parameter int unsigned N_EDGES = N_EDGES_DEFAULT,
    parameter int unsigned TW      = 8,
    parameter int unsigned TH      = 8,
    localparam int unsigned XB     = $clog2(TW),
    localparam int unsigned YB     = $clog2(TH),
    localparam int unsigned CB     = $clog2(TW * TH + 1)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    output logic                 start_ready,
    input  logic [W*N_EDGES-1:0] a,
    input  logic [W*N_EDGES-1:0] b,
    input  logic [W*N_EDGES-1:0] c,
    input  logic                 abort,
    output logic                 pix_valid,
    input  logic                 pix_ready,
    output logic [XB-1:0]        pix_x,
    output logic [YB-1:0]        pix_y,
    output logic                 pix_inside,
    output logic                 pix_last,
    output logic                 done,
    output logic [CB-1:0]        cover_count
);

    localparam int unsigned LW = W * N_EDGES;
    localparam logic [XB-1:0] XMax = XB'(TW - 1);
    localparam logic [YB-1:0] YMax = YB'(TH - 1);

    state_e        state_q, state_d;
    logic [LW-1:0] a_q, a_d;
    logic [LW-1:0] b_q, b_d;
    logic [LW-1:0] e_q, e_d;
    logic [XB-1:0] x_q, x_d;
    logic [YB-1:0] y_q, y_d;
    logic [CB-1:0] cnt_q, cnt_d;
    logic [CB-1:0] cover_q, cover_d;
    logic          done_q, done_d;

    logic [LW-1:0] x_sum, y_sum;
    logic [LW-1:0] y_base;
    logic          x_sub;
    logic          y_inside_unused;
    logic          row_end;
    logic [XB-1:0] x_next;
    logic [XB-1:0] last_x;
    logic          xfer;

`ifdef TILE_SCAN_SERPENTINE_EN
    // Row advance steps straight down from the current pixel, so no row-start copy is kept.
    assign y_base  = e_q;
    assign x_sub   = y_q[0];
    assign row_end = y_q[0] ? (x_q == '0) : (x_q == XMax);
    assign x_next  = y_q[0] ? (x_q - XB'(1)) : (x_q + XB'(1));
    assign last_x  = (((TH - 1) % 2) == 1) ? '0 : XMax;
`else
    logic [LW-1:0] e0_q, e0_d;

    assign y_base  = e0_q;
    assign x_sub   = 1'b0;
    assign row_end = (x_q == XMax);
    assign x_next  = x_q + XB'(1);
    assign last_x  = XMax;
`endif

    tile_edge_step #(
        .W (W),
        .N (N_EDGES)
    ) u_x_step (
        .e_i      (e_q),
        .d_i      (a_q),
        .sub_i    (x_sub),
        .sum_o    (x_sum),
        .inside_o (pix_inside)
    );

    tile_edge_step #(
        .W (W),
        .N (N_EDGES)
    ) u_y_step (
        .e_i      (y_base),
        .d_i      (b_q),
        .sub_i    (1'b0),
        .sum_o    (y_sum),
        .inside_o (y_inside_unused)
    );

    assign pix_valid   = (state_q == RUN);
    assign start_ready = (state_q == IDLE);
    assign pix_x       = x_q;
    assign pix_y       = y_q;
    assign pix_last    = pix_valid && (x_q == last_x) && (y_q == YMax);
    assign done        = done_q;
    assign cover_count = cover_q;
    assign xfer        = pix_valid && pix_ready;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        e_d     = e_q;
        x_d     = x_q;
        y_d     = y_q;
        cnt_d   = cnt_q;
        cover_d = cover_q;
        done_d  = 1'b0;
`ifndef TILE_SCAN_SERPENTINE_EN
        e0_d    = e0_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    e_d     = c;
`ifndef TILE_SCAN_SERPENTINE_EN
                    e0_d    = c;
`endif
                    x_d     = '0;
                    y_d     = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // abort wins over a transfer in the same cycle
                if (abort) begin
                    state_d = IDLE;
                end else if (xfer) begin
                    cnt_d = cnt_q + CB'(pix_inside);
                    if (!row_end) begin
                        e_d = x_sum;
                        x_d = x_next;
                    end else if (y_q != YMax) begin
                        e_d = y_sum;
`ifndef TILE_SCAN_SERPENTINE_EN
                        e0_d = y_sum;
                        x_d  = '0;
`endif
                        y_d = y_q + YB'(1);
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        cover_d = cnt_q + CB'(pix_inside);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            e_q     <= '0;
            x_q     <= '0;
            y_q     <= '0;
            cnt_q   <= '0;
            cover_q <= '0;
            done_q  <= 1'b0;
`ifndef TILE_SCAN_SERPENTINE_EN
            e0_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            e_q     <= e_d;
            x_q     <= x_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
            cover_q <= cover_d;
            done_q  <= done_d;
`ifndef TILE_SCAN_SERPENTINE_EN
            e0_q    <= e0_d;
`endif
        end
    end

endmodule

// File: tb/tb_tile_scan.sv
// Randomised and directed bench for tile_scan on a 4x4 tile with three edges.
module tb_tile_scan;

    localparam int W    = 18;
    localparam int N    = 3;
    localparam int TW   = 4;
    localparam int TH   = 4;
    localparam int XB   = $clog2(TW);
    localparam int YB   = $clog2(TH);
    localparam int CB   = $clog2(TW * TH + 1);
    localparam int NPIX = TW * TH;
    localparam int LW   = W * N;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          pix_ready = 1'b0;
    logic [LW-1:0] a = '0;
    logic [LW-1:0] b = '0;
    logic [LW-1:0] c = '0;
    logic          start_ready;
    logic          pix_valid;
    logic [XB-1:0] pix_x;
    logic [YB-1:0] pix_y;
    logic          pix_inside;
    logic          pix_last;
    logic          done;
    logic [CB-1:0] cover_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    tile_scan #(
        .W       (W),
        .N_EDGES (N),
        .TW      (TW),
        .TH      (TH)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .start_ready (start_ready),
        .a           (a),
        .b           (b),
        .c           (c),
        .abort       (abort),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .pix_inside  (pix_inside),
        .pix_last    (pix_last),
        .done        (done),
        .cover_count (cover_count)
    );

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Edge value at (x, y) is c + a*x + b*y modulo 2^W, independent of scan order.
    function automatic bit model_inside(input logic [LW-1:0] av, input logic [LW-1:0] bv,
                                        input logic [LW-1:0] cv, input int x, input int y);
        logic [W-1:0] v;
        for (int i = 0; i < N; i++) begin
            v = cv[W*i +: W] + av[W*i +: W] * W'(x) + bv[W*i +: W] * W'(y);
            if (v[W-1]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic int order_x(input int k);
        int xi;
        xi = k % TW;
`ifdef TILE_SCAN_SERPENTINE_EN
        if (((k / TW) % 2) == 1) xi = TW - 1 - xi;
`endif
        return xi;
    endfunction

    // Entered and left at a negedge with the DUT idle. mode: 0 ready always, 1 toggling,
    // 2 random (also disturbs start/a/b/c mid-scan). abort_at < 0 disables abort.
    task automatic run_tile(input logic [LW-1:0] av, input logic [LW-1:0] bv,
                            input logic [LW-1:0] cv, input int mode, input int abort_at);
        int                k;
        int                cyc;
        int                exp_cover;
        int                ex;
        int                ey;
        bit                stalled;
        bit                rdy;
        logic [XB+YB+2:0]  held;
        logic [CB-1:0]     cover_before;
        k         = 0;
        cyc       = 0;
        exp_cover = 0;
        stalled   = 1'b0;
        held      = '0;
        check_eq("start_ready_idle", start_ready, 1);
        cover_before = cover_count;
        start = 1'b1;
        a = av;
        b = bv;
        c = cv;
        @(negedge clock);
        start = 1'b0;
        while (k < NPIX && cyc < 400) begin
            check_eq("valid", pix_valid, 1);
            check_eq("start_ready_run", start_ready, 0);
            check_eq("done_early", done, 0);
            if (stalled) check_eq("stall_hold", {pix_x, pix_y, pix_inside, pix_last, pix_valid},
                                  held);
            if (mode == 2) begin
                start = 1'($urandom_range(1));
                a = LW'({$urandom, $urandom});
                b = LW'({$urandom, $urandom});
                c = LW'({$urandom, $urandom});
            end
            if (abort_at == k) begin
                abort = 1'b1;
                pix_ready = 1'b1;
                @(negedge clock);
                abort = 1'b0;
                pix_ready = 1'b0;
                start = 1'b0;
                check_eq("abort_valid", pix_valid, 0);
                check_eq("abort_done", done, 0);
                check_eq("abort_start_ready", start_ready, 1);
                check_eq("abort_cover", cover_count, cover_before);
                return;
            end
            rdy = (mode == 0) ? 1'b1 : (mode == 1) ? ((cyc % 2) == 0) : 1'($urandom_range(1));
            pix_ready = rdy;
            if (rdy) begin
                ex = order_x(k);
                ey = k / TW;
                check_eq("pix_x", pix_x, ex);
                check_eq("pix_y", pix_y, ey);
                check_eq("pix_inside", pix_inside, model_inside(av, bv, cv, ex, ey));
                check_eq("pix_last", pix_last, (k == NPIX - 1));
                if (model_inside(av, bv, cv, ex, ey)) exp_cover++;
                k++;
            end
            stalled = !rdy;
            held = {pix_x, pix_y, pix_inside, pix_last, pix_valid};
            @(negedge clock);
            cyc++;
        end
        start = 1'b0;
        pix_ready = 1'b0;
        check_eq("timeout", k, NPIX);
        check_eq("done_pulse", done, 1);
        check_eq("end_valid", pix_valid, 0);
        check_eq("cover_count", cover_count, exp_cover);
        check_eq("end_start_ready", start_ready, 1);
    endtask

    initial begin
        logic [LW-1:0] a1;
        logic [LW-1:0] c1;
        logic [LW-1:0] c3;
        logic [LW-1:0] zero;
        logic [LW-1:0] ar;
        logic [LW-1:0] br;
        logic [LW-1:0] cr;
        zero = '0;
        a1 = '0;
        a1[W-1:0] = W'(1);
        c1 = '0;
        c1[W-1:0] = {W{1'b1}} - W'(1);
        c3 = '0;
        c3[W-1:0] = {1'b0, {(W - 1){1'b1}}};

        #1;
        check_eq("rst_valid", pix_valid, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_cover", cover_count, 0);
        check_eq("rst_x", pix_x, 0);
        check_eq("rst_y", pix_y, 0);
        check_eq("rst_start_ready", start_ready, 1);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        run_tile(a1, zero, c1, 0, -1);
        check_eq("cover_directed", cover_count, 8);
        // next start lands in the done cycle
        run_tile(a1, zero, c1, 1, -1);
        check_eq("cover_stall", cover_count, 8);
        @(negedge clock);
        check_eq("done_one_cycle", done, 0);

        run_tile(a1, zero, c3, 0, -1);
        check_eq("cover_wrap", cover_count, 4);
        @(negedge clock);

        run_tile(a1, zero, c1, 0, 5);
        run_tile(zero, zero, zero, 0, -1);
        check_eq("cover_all", cover_count, 16);
        @(negedge clock);

        start = 1'b1;
        a = a1;
        b = zero;
        c = c1;
        @(negedge clock);
        start = 1'b0;
        pix_ready = 1'b1;
        repeat (5) @(negedge clock);
        @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        check_eq("async_rst_valid", pix_valid, 0);
        check_eq("async_rst_cover", cover_count, 0);
        check_eq("async_rst_start_ready", start_ready, 1);
        @(negedge clock);
        reset = 1'b0;
        pix_ready = 1'b0;
        @(negedge clock);

        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < N; i++) begin
                if (t == 7) begin
                    ar[W*i +: W] = W'($urandom);
                    br[W*i +: W] = W'($urandom);
                    cr[W*i +: W] = W'($urandom);
                end else begin
                    ar[W*i +: W] = W'($urandom_range(10)) - W'(5);
                    br[W*i +: W] = W'($urandom_range(10)) - W'(5);
                    cr[W*i +: W] = W'($urandom_range(40)) - W'(20);
                end
            end
            run_tile(ar, br, cr, 2, -1);
            if (t % 2 == 0) @(negedge clock);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tile_scan.md
Name: tile_scan

Overview:
- Parametrised successor to the triangle tile renderer: holds N_EDGES edge-function accumulators and autonomously walks a TW x TH pixel tile.
- Replaces the external nop/restart/stepy/stepx command bus with a start handshake and an internal scan sequencer.
- Emits one coverage sample per pixel on a valid/ready stream and reports the covered-pixel count at tile end.
- Sits between triangle setup (supplies a, b, c) and the pixel/shade stage.

Parameters:
- W, 18, edge-function width in bits (two's complement).
- N_EDGES, 3, number of edge functions evaluated in parallel.
- TW, 8, tile width in pixels (>=2).
- TH, 8, tile height in pixels (>=2).
- Derived: XB = $clog2(TW), YB = $clog2(TH), CB = $clog2(TW*TH+1).

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  request a tile scan; accepted when start && start_ready
- start_ready  out  1  high in IDLE only
- a  in  W*N_EDGES  per-edge x step; lane i at [W*i +: W]; sampled at start accept
- b  in  W*N_EDGES  per-edge y step; sampled at start accept
- c  in  W*N_EDGES  per-edge value at pixel (0,0); sampled at start accept
- abort  in  1  synchronous scan cancel
- pix_valid  out  1  pixel sample valid
- pix_ready  in  1  downstream accepts sample
- pix_x  out  XB  pixel column
- pix_y  out  YB  pixel row
- pix_inside  out  1  all edges non-negative at (pix_x, pix_y)
- pix_last  out  1  marks the final pixel of the tile
- done  out  1  one-cycle pulse after the last pixel transfers
- cover_count  out  CB  number of transferred samples with pix_inside=1; valid when done=1 and held until the next start

Behaviour:
- Reset (async, active-high) values: state IDLE; pix_valid=0, done=0, cover_count=0, pix_x=0, pix_y=0. Edge registers e, e0 and a/b latches are cleared to 0.
- States:
  - IDLE: start_ready=1.
  - RUN.
- Start accept (IDLE & start):
  - Latch a and b.
  - e <= c, e0 <= c, x=0, y=0, internal count=0.
  - Go to RUN. pix_valid=1 on the next cycle (latency 1) with pixel (0,0).
- pix_inside: combinational from registered e; it is the NOR of the sign bits of all N_EDGES lanes, so zero counts as inside.
- Transfer occurs when pix_valid & pix_ready. On each transfer, count += pix_inside, then:
  - If x < TW-1: e <= e + a lane-wise, x++.
  - Else if y < TH-1: e0 <= e0 + b, e <= e0 + b, x=0, y++.
  - Else: go to IDLE, pix_valid=0, done=1 for one cycle, cover_count <= count + pix_inside.
- Stall (pix_valid & !pix_ready): e, e0, x, y and all outputs are held stable.
- pix_last = (pix_x==TW-1) & (pix_y==TH-1) & pix_valid.
- Arithmetic: each lane is W-bit two's complement, wrapping modulo 2^W. No saturation, no overflow flag.
- abort in RUN: next cycle go to IDLE, pix_valid=0, done=0, cover_count unchanged. abort has priority over a simultaneous transfer. abort in IDLE is ignored.
- start while in RUN is ignored (start_ready=0).
- Start in the same cycle as done: accepted, because the block is already IDLE in the done cycle.
- Reset mid-scan: immediate return to reset values; the partial tile is discarded.

Optional Feature:
- Macro: TILE_SCAN_SERPENTINE_EN.
- Defined:
  - Odd rows scan x from TW-1 down to 0 with e <= e - a.
  - Row advance is e <= e + b directly from the current e; e0 is not instantiated.
  - pix_x reports the true column; pix_last is at x=0 when TH is even, x=TW-1 when TH is odd.
- Undefined: raster order only, as specified above.
- The set of (x, y, pix_inside) tuples and cover_count are identical either way.

Decomposition:
- Package tile_pkg holds:
  - default W and N_EDGES;
  - the state enum {IDLE, RUN};
  - the lane-slice convention [W*i +: W].
- Sub-module tile_edge_step: N_EDGES parallel W-bit adders with a per-call add/subtract select and a sign-bit inside reduction. Instantiated once for the x step and once for the y step.

Test Plan:
- TW=TH=4, N_EDGES=3. Edge0 c=-2, a=1, b=0; edges 1 and 2 c=0, a=b=0; pix_ready=1 -> 16 samples, inside exactly at x>=2, pix_last on sample 16, done pulse, cover_count=8.
- Same setup with pix_ready toggling 1,0,1,0 -> outputs stable during stalls; same 16 tuples; cover_count=8.
- Edge0 c=2^(W-1)-1, a=1 -> x=1 wraps negative; pix_inside=0 from x=1 onward; cover_count=4 (x=0 of each row).
- Assert abort after 5 transfers -> pix_valid=0 next cycle, no done, start_ready=1. A following start with all c=0 and a=b=0 -> cover_count=16.
- Assert reset asynchronously mid-row -> pix_valid drops with no clock edge; cover_count=0.
- With TILE_SCAN_SERPENTINE_EN defined: row1 x order is 3,2,1,0; same inside set and cover_count=8 as scenario 1.
